// File: rtl/secuenciador_aritmetica.sv
// secuenciador_aritmetica: time-multiplexes one shared MAC datapath
// to compute a TAPS-tap FIR output for every accepted input sample.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/valid     sample source; in_ready high only in IDLE
//   out_data/valid    result to consumer; out_ready accepts it
//   cfg_we/addr/data  coefficient writes; cfg_ack pulses one cycle later
//   Constantes_G      datapath operand: accumulator
//   Multip_G          datapath operand: coefficient[k]
//   Entrada_G         datapath operand: delay line[k]
//   Valores           datapath result, valid in the same cycle
module secuenciador_aritmetica #(
    parameter int N    = 25,
    parameter int TAPS = 5,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [N-1:0] cfg_data,
    output logic         cfg_ack,
    output logic [N-1:0] Constantes_G,
    output logic [N-1:0] Multip_G,
    output logic [N-1:0] Entrada_G,
    input  logic [N-1:0] Valores
);

    localparam int KW = 4;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    // The tap index and cfg_addr are 4 bits wide, and the Q format
    // must leave at least one integer bit in the word.
    if (TAPS < 2 || TAPS > 16 || FRAC >= N) begin : g_bad_params
        $error("secuenciador_aritmetica: need 2<=TAPS<=16, FRAC<N");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [N-1:0]    acc_q;
    logic [N-1:0]    d_q    [TAPS];
    logic [N-1:0]    coef_q [TAPS];
    logic [N-1:0]    out_data_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            cfg_ack_q;

    logic            accept;
    logic            cfg_hit;

    // in_ready is registered so that it stays low during reset and
    // for the first cycle afterwards; a sample is only taken when
    // the handshake is actually offered.
    assign accept = (state_q == S_IDLE) && in_ready_q && in_valid;

    // A sample arriving in the same cycle takes priority over a
    // coefficient write; out-of-range writes are silently dropped.
    assign cfg_hit = (state_q == S_IDLE) && !in_valid && cfg_we
                     && (int'(cfg_addr) < TAPS);

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cfg_ack   = cfg_ack_q;

    // Operand buses are only live during MAC so the shared datapath
    // sees zeros whenever this controller is not using it.
    always_comb begin
        Constantes_G = '0;
        Multip_G     = '0;
        Entrada_G    = '0;
        if (state_q == S_MAC) begin
            Constantes_G = acc_q;
            for (int i = 0; i < TAPS; i++) begin
                if (k_q == KW'(i)) begin
                    Multip_G  = coef_q[i];
                    Entrada_G = d_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cfg_ack_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                d_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            cfg_ack_q <= cfg_hit;
            for (int i = 0; i < TAPS; i++) begin
                if (cfg_hit && cfg_addr == KW'(i)) begin
                    coef_q[i] <= cfg_data;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        d_q[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) begin
                            d_q[i] <= d_q[i-1];
                        end
                        acc_q      <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MAC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q <= Valores;
                    if (k_q == K_LAST) begin
                        out_data_q  <= Valores;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_aritmetica.sv
// Bench for secuenciador_aritmetica: a behavioural Aritmetica
// datapath plus a FIR reference model over sample history.
module tb_secuenciador_aritmetica;

    localparam int N    = 25;
    localparam int TAPS = 5;
    localparam int FRAC = 10;
    localparam int SMAX = (1 << (N - 1)) - 1;
    localparam int SMIN = -(1 << (N - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [N-1:0] cfg_data;
    logic         cfg_ack;
    logic [N-1:0] Constantes_G;
    logic [N-1:0] Multip_G;
    logic [N-1:0] Entrada_G;
    logic [N-1:0] Valores;

    int checks = 0;
    int errors = 0;

    int coef_m [TAPS];
    int hist_m [TAPS];

    always #5 clk = ~clk;

    secuenciador_aritmetica #(
        .N(N), .TAPS(TAPS), .FRAC(FRAC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .Constantes_G (Constantes_G),
        .Multip_G     (Multip_G),
        .Entrada_G    (Entrada_G),
        .Valores      (Valores)
    );

    // sat25(a + ((c * d) >>> FRAC)) in plain integer arithmetic
    function automatic int dp(input int a, input int c, input int d);
        longint p;
        longint s;
        p = (longint'(c) * longint'(d)) >>> FRAC;
        s = longint'(a) + p;
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
        return int'(s);
    endfunction

    assign Valores = N'(dp(int'($signed(Constantes_G)),
                           int'($signed(Multip_G)),
                           int'($signed(Entrada_G))));

    function automatic int model_sample(input int x);
        int acc;
        for (int i = TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = x;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc = dp(acc, coef_m[k], hist_m[k]);
        return acc;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            coef_m[i] = 0;
            hist_m[i] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic cfg_write(input int addr, input int val,
                             output logic ack);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = N'(val);
        tick();
        ack    = cfg_ack;
        cfg_we = 1'b0;
    endtask

    // Offers one sample, reports result and edges-to-valid, then
    // lets the consumer accept after 'hold' extra cycles.
    task automatic push(input int x, input int hold,
                        output logic [N-1:0] y, output int lat);
        int w;
        w = 0;
        y = '0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            lat = -1;
            return;
        end
        in_data  = N'(x);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
            return;
        end
        y = out_data;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int e;
        do_reset();
        cfg_write(0, 1024, ack);
        coef_m[0] = 1024;
        cfg_write(1, 1024, ack);
        coef_m[1] = 1024;
        push(500, 0, y, lat);
        e = model_sample(500);
        checks++;
        if (y !== N'(e) || lat != TAPS) begin
            errors++;
            $display("FAIL reset_pre: out=%0d lat=%0d want %0d lat %0d",
                     $signed(y), lat, e, TAPS);
        end
        in_data  = N'(600);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, cfg_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: rdy/vld/ack=%b want 000",
                     {in_ready, out_valid, cfg_ack});
        end
        checks++;
        if (out_data !== '0 || Constantes_G !== '0
            || Multip_G !== '0 || Entrada_G !== '0) begin
            errors++;
            $display("FAIL reset_data: out=%h C=%h M=%h E=%h want 0",
                     out_data, Constantes_G, Multip_G, Entrada_G);
        end
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_early: in_ready=%b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        cfg_write(1, 1024, ack);
        coef_m[1] = 1024;
        push(999, 0, y, lat);
        e = model_sample(999);
        checks++;
        if (y !== N'(e) || lat != TAPS) begin
            errors++;
            $display("FAIL reset_history: out=%0d lat=%0d want %0d",
                     $signed(y), lat, e);
        end
    endtask

    task automatic test_identity();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int xs [3] = '{300, -7, 12};
        do_reset();
        cfg_write(0, 1024, ack);
        coef_m[0] = 1024;
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ident_ack: ack=%b want 1", ack);
        end
        for (int i = 0; i < 3; i++) begin
            push(xs[i], i, y, lat);
            void'(model_sample(xs[i]));
            checks++;
            if (y !== N'(xs[i]) || lat != TAPS) begin
                errors++;
                $display("FAIL identity[%0d]: out=%0d lat=%0d want %0d lat %0d",
                         i, $signed(y), lat, xs[i], TAPS);
            end
        end
    endtask

    task automatic test_averager();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int e;
        int want [5] = '{205, 410, 615, 820, 1025};
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            cfg_write(k, 205, ack);
            coef_m[k] = 205;
        end
        for (int i = 0; i < 5; i++) begin
            push(1024, 0, y, lat);
            e = model_sample(1024);
            checks++;
            if (y !== N'(want[i]) || y !== N'(e) || lat != TAPS) begin
                errors++;
                $display("FAIL average[%0d]: out=%0d lat=%0d want %0d",
                         i, $signed(y), lat, want[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int e;
        int xs [4] = '{1 << 23, 1 << 23, -(1 << 23), -(1 << 23)};
        do_reset();
        cfg_write(0, SMAX, ack);
        coef_m[0] = SMAX;
        cfg_write(1, SMAX, ack);
        coef_m[1] = SMAX;
        for (int i = 0; i < 4; i++) begin
            push(xs[i], 0, y, lat);
            e = model_sample(xs[i]);
            checks++;
            if (y !== N'(e) || lat != TAPS) begin
                errors++;
                $display("FAIL saturate[%0d]: out=%0d want %0d",
                         i, $signed(y), e);
            end
        end
        checks++;
        if (y !== N'(SMIN)) begin
            errors++;
            $display("FAIL saturate_neg: out=%0d want %0d",
                     $signed(y), SMIN);
        end
    endtask

    task automatic test_backpressure();
        logic ack;
        logic [N-1:0] y;
        logic [N-1:0] y0;
        int lat;
        int e;
        int w;
        do_reset();
        cfg_write(0, 1024, ack);
        coef_m[0] = 1024;
        cfg_write(2, -512, ack);
        coef_m[2] = -512;
        push(1000, 0, y, lat);
        void'(model_sample(1000));
        in_data  = N'(333);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        e = model_sample(333);
        w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        y0 = out_data;
        checks++;
        if (out_valid !== 1'b1 || y0 !== N'(e)) begin
            errors++;
            $display("FAIL bp_first: vld=%b out=%0d want 1 %0d",
                     out_valid, $signed(y0), e);
        end
        in_data  = N'(4444);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== N'(e)
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b out=%0d rdy=%b want 1 %0d 0",
                         i, out_valid, $signed(out_data), in_ready, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        push(50, 0, y, lat);
        e = model_sample(50);
        checks++;
        if (y !== N'(e) || lat != TAPS) begin
            errors++;
            $display("FAIL bp_next: out=%0d want %0d", $signed(y), e);
        end
    endtask

    task automatic test_config();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int e;
        int w;
        do_reset();
        cfg_write(0, 1024, ack);
        coef_m[0] = 1024;
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = N'(4096);
        in_data  = N'(77);
        in_valid = 1'b1;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        e = model_sample(77);
        checks++;
        if (in_ready !== 1'b0 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_collide: rdy=%b ack=%b want 0 0",
                     in_ready, cfg_ack);
        end
        w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== N'(e)) begin
            errors++;
            $display("FAIL cfg_collide_out: out=%0d want %0d",
                     $signed(out_data), e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cfg_write(7, 999, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_addr7: ack=%b want 0", ack);
        end
        cfg_write(1, 2048, ack);
        coef_m[1] = 2048;
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ack_pulse: ack=%b want 1", ack);
        end
        tick();
        checks++;
        if (cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ack_len: ack=%b want 0", cfg_ack);
        end
        in_data  = N'(10);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = '0;
        tick();
        cfg_we = 1'b0;
        e = model_sample(10);
        checks++;
        if (cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_in_mac: ack=%b want 0", cfg_ack);
        end
        w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== N'(e)) begin
            errors++;
            $display("FAIL cfg_in_mac_out: out=%0d want %0d",
                     $signed(out_data), e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push(-20, 0, y, lat);
        e = model_sample(-20);
        checks++;
        if (y !== N'(e) || lat != TAPS) begin
            errors++;
            $display("FAIL cfg_after: out=%0d want %0d", $signed(y), e);
        end
    endtask

    task automatic test_random();
        logic ack;
        logic [N-1:0] y;
        int lat;
        int e;
        int v;
        int x;
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            v = int'($urandom_range(6000)) - 3000;
            cfg_write(k, v, ack);
            coef_m[k] = v;
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL rand_cfg[%0d]: ack=%b want 1", k, ack);
            end
        end
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(1 << 23)) - (1 << 22);
            push(x, int'($urandom_range(3)), y, lat);
            e = model_sample(x);
            checks++;
            if (y !== N'(e) || lat != TAPS) begin
                errors++;
                $display("FAIL rand[%0d]: in=%0d out=%0d lat=%0d want %0d",
                         i, x, $signed(y), lat, e);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        model_clear();
        test_reset();
        test_identity();
        test_averager();
        test_saturation();
        test_backpressure();
        test_config();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
